// File: rtl/ring_counter.sv
// rtl/ring_counter.sv - one-hot ring counter with optional illegal-state recovery
module ring_counter #(
  parameter int N            = 4,
  parameter bit SHIFT_LEFT   = 1'b1,
  parameter bit SELF_CORRECT = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  output logic [N-1:0] q
);

  if (N < 2) begin : g_bad_width
    $error("ring_counter: N must be at least 2");
  end

  localparam logic [N-1:0] RING_START = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] state_q;
  logic [N-1:0] state_d;
  logic [N-1:0] rotated;
  logic         one_hot;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign one_hot = (state_q != '0) && ((state_q & (state_q - RING_START)) == '0);

  always_comb begin
    rotated = state_q;
    if (SHIFT_LEFT) begin
      rotated = {state_q[N-2:0], state_q[N-1]};
    end else begin
      rotated = {state_q[0], state_q[N-1:1]};
    end
  end

  always_comb begin
    state_d = rotated;
    if (SELF_CORRECT && !one_hot) begin
      state_d = RING_START;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RING_START;
    end else begin
      state_q <= state_d;
    end
  end

  assign q = state_q;

endmodule

// File: tb/tb_ring_counter.sv
// tb/tb_ring_counter.sv - scoreboard bench for ring_counter across five configurations
module tb_ring_counter;

  typedef logic [7:0] vec_t;
  typedef logic [4:0][7:0] row_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [3:0] q_l4, q_r4, q_n4;
  logic [1:0] q_l2;
  logic [7:0] q_l8;

  ring_counter #(.N(4), .SHIFT_LEFT(1'b1), .SELF_CORRECT(1'b1)) u_l4 (.clk(clk), .rst(rst), .q(q_l4));
  ring_counter #(.N(4), .SHIFT_LEFT(1'b0), .SELF_CORRECT(1'b1)) u_r4 (.clk(clk), .rst(rst), .q(q_r4));
  ring_counter #(.N(4), .SHIFT_LEFT(1'b1), .SELF_CORRECT(1'b0)) u_n4 (.clk(clk), .rst(rst), .q(q_n4));
  ring_counter #(.N(2), .SHIFT_LEFT(1'b1), .SELF_CORRECT(1'b1)) u_l2 (.clk(clk), .rst(rst), .q(q_l2));
  ring_counter #(.N(8), .SHIFT_LEFT(1'b1), .SELF_CORRECT(1'b1)) u_l8 (.clk(clk), .rst(rst), .q(q_l8));

  int   nbits [5] = '{4, 4, 4, 2, 8};
  bit   lft   [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  bit   corr  [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

  int   checks = 0;
  int   errors = 0;
  row_t sb_q[$];
  row_t model;
  vec_t fv;
  int   hold_cnt = 0;

  always begin
    #5;
    if (run) clk = ~clk;
  end

  function automatic vec_t act_of(int k);
    case (k)
      0: return {4'b0, q_l4};
      1: return {4'b0, q_r4};
      2: return {4'b0, q_n4};
      3: return {6'b0, q_l2};
      default: return q_l8;
    endcase
  endfunction

  function automatic vec_t mask_of(int n);
    vec_t m = '0;
    for (int i = 0; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Spec rule: non-one-hot with recovery -> 1; otherwise every set bit moves one slot around the ring.
  function automatic vec_t ref_next(vec_t cur, int n, bit left, bit sc);
    int   ones = 0;
    vec_t r = '0;
    for (int i = 0; i < n; i++) if (cur[i]) ones++;
    if (sc && ones != 1) return 8'd1;
    for (int i = 0; i < n; i++) begin
      if (cur[i]) r[left ? (i + 1) % n : (i + n - 1) % n] = 1'b1;
    end
    return r;
  endfunction

  task automatic check(string name, int k, vec_t act, vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst=%0d actual=%b required=%b t=%0t", name, k, act, exp, $time);
    end
  endtask

  task automatic check_all_one(string name);
    for (int k = 0; k < 5; k++) check(name, k, act_of(k), 8'd1);
  endtask

  task do_force(int k, vec_t v);
    fv = v & mask_of(nbits[k]);
    case (k)
      0: force u_l4.state_q = fv[3:0];
      1: force u_r4.state_q = fv[3:0];
      2: force u_n4.state_q = fv[3:0];
      3: force u_l2.state_q = fv[1:0];
      default: force u_l8.state_q = fv;
    endcase
    #1;
    case (k)
      0: release u_l4.state_q;
      1: release u_r4.state_q;
      2: release u_n4.state_q;
      3: release u_l2.state_q;
      default: release u_l8.state_q;
    endcase
    model[k] = fv;
  endtask

  task pulse_reset();
    rst = 1'b0;
    #1 check_all_one("rst_async_mid");
    #1 rst = 1'b1;
    for (int k = 0; k < 5; k++) model[k] = 8'd1;
  endtask

  initial begin : monitor
    row_t exp;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() != 0) begin
        exp = sb_q.pop_front();
        for (int k = 0; k < 5; k++) check("edge", k, act_of(k), exp[k]);
      end
    end
  end

  initial begin : stimulus
    row_t e;
    int   r;
    #2 rst = 1'b0;
    #1 check_all_one("rst_async_no_clk");
    #1 rst = 1'b1;
    #1 check_all_one("rst_release_hold");
    for (int k = 0; k < 5; k++) model[k] = 8'd1;
    run = 1'b1;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 5; k++) begin
        e[k] = !rst ? 8'd1 : ref_next(model[k], nbits[k], lft[k], corr[k]);
      end
      sb_q.push_back(e);
      model = e;
      @(posedge clk);
      @(negedge clk);
      if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) rst = 1'b1;
      end else if (i == 3)  do_force(0, 8'h00);
      else if (i == 6)  do_force(0, 8'h06);
      else if (i == 9)  do_force(2, 8'h06);
      else if (i == 12) do_force(1, 8'h06);
      else if (i == 15) do_force(4, 8'h81);
      else if (i == 18) do_force(3, 8'h03);
      else if (i == 21) pulse_reset();
      else if (i == 25) begin
        rst = 1'b0;
        #1 check_all_one("rst_async_hold");
        hold_cnt = 2;
        for (int k = 0; k < 5; k++) model[k] = 8'd1;
      end else if (i >= 40) begin
        r = $urandom_range(0, 99);
        if (r < 3) pulse_reset();
        else if (r < 5) begin
          rst = 1'b0;
          #1 check_all_one("rst_async_hold");
          hold_cnt = $urandom_range(1, 3);
          for (int k = 0; k < 5; k++) model[k] = 8'd1;
        end else if (r < 20) begin
          do_force($urandom_range(0, 4), vec_t'($urandom_range(0, 255)));
        end
      end
    end
    @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0 pending", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ring_counter.md
# ring_counter

Parameterised one-hot ring counter: a single `1` circulates through an N-bit register, advancing one position per clock. It provides sequencing strobes, such as phase selects and round-robin slot enables, to surrounding control logic. The block includes illegal-state detection with automatic recovery, so a corrupted register returns to a valid one-hot sequence on its own.

## Interface
- `N`, default 4: register width and ring length; legal range N >= 2. Elaboration fails on N < 2.
- `SHIFT_LEFT`, default 1: 1 rotates toward the MSB, 0 rotates toward the LSB.
- `SELF_CORRECT`, default 1: 1 enables illegal-state recovery, 0 performs a pure rotate.

- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low. Asserting it forces `q` immediately, independent of `clk`.
- `q`  output  N  ring state, driven directly from the register; exactly one bit is high in normal operation.
- Port order is `clk`, `rst`, `q`; positional instantiation is supported.

## Operation
- Reset value: `q` = 1, meaning bit 0 high and all others low, for example 4'b0001.
- With `SHIFT_LEFT`=1, each rising edge rotates left: new `q` = {q[N-2:0], q[N-1]}.
  - Sequence for N=4: 0001 → 0010 → 0100 → 1000 → 0001.
- With `SHIFT_LEFT`=0, each rising edge rotates right: new `q` = {q[0], q[N-1:1]}.
  - Sequence for N=4: 0001 → 1000 → 0100 → 0010 → 0001.
- Wrap-around: the MSB feeds bit 0 (left mode), or bit 0 feeds the MSB (right mode). The period is exactly N clocks.
- Illegal-state recovery, when `SELF_CORRECT`=1:
  - If the current `q` is not one-hot (zero bits set, or two or more bits set), the next rising edge loads `q` = 1 instead of rotating.
  - The one-hot check is combinational on the register output and takes priority over rotation.
- With `SELF_CORRECT`=0, an illegal state simply rotates. For example, 0000 stays 0000 and 0011 rotates to 0110.
- No enable input: the counter advances on every clock edge while `rst` is high.

## Timing
- Latency is one clock from a rising edge to the updated `q`. There is no combinational path from any input to `q`.
- Reset assertion (`rst` falling to 0): `q` = 1 within the same delta or timestep, with no clock required. It holds at 1 on every edge while `rst` = 0.
- Reset release (`rst` rising to 1): the first rising edge after release produces the second ring state, 0010 in left mode.
  - Release coincident with a clock edge: that edge does not advance; the next edge does.
- Reset mid-operation, from any state: `q` returns to 1 asynchronously, and the sequence restarts from bit 0 after release.
- Steady state: each bit is high for exactly 1 clock out of every N. The duty cycle per bit is 1/N.

## Test plan
- Reset: drive `rst`=0 with `clk` stopped → `q` = 4'b0001 immediately. Release `rst` → `q` stays 0001 until the next rising edge.
- Full rotation: N=4, default parameters, release reset and run 2N = 8 edges → `q` = 0010, 0100, 1000, 0001, 0010, 0100, 1000, 0001.
- Mid-run reset: with `q` = 0100, pulse `rst` low between clock edges → `q` = 0001 before the next edge. After release, the sequence resumes as 0010, 0100, and so on.
- Right rotation: `SHIFT_LEFT`=0, N=4 → after reset the sequence is 1000, 0100, 0010, 0001, with the wrap checked.
- Self-correction: `SELF_CORRECT`=1, force `q` to 0000 and, separately, to 0110 → the next edge gives `q` = 0001. With `SELF_CORRECT`=0, 0110 rotates to 1100.
- Width scaling: N=2 and N=8 → the period is N edges, exactly one bit is high at every edge, and the MSB wraps to bit 0.
